// File: rtl/bcd_seq_pkg.sv
// Shared types and helpers for the sequential packed-BCD to binary converter.
package bcd_seq_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} conv_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Digit counter width; a single-digit converter still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bcd_to_binary.sv
// Single BCD digit to binary unit shared by the sequential converter.
module bcd_to_binary
    import bcd_seq_pkg::*;
(
    input  bcd_digit_t  bcd,
    output logic [3:0]  bin
);

    // A legal BCD digit already equals its binary value; nibbles 10-15 pass through.
    assign bin = bcd;

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-digit packed-BCD to binary converter, MSB digit first, acc = acc*10 + digit.
// Optional invalid-digit detection is enabled by defining BCD_ERR_CHECK_EN.
module bcd_seq_converter
    import bcd_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 14
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BIN_W-1:0]        out_bin,
    output logic                    out_err,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(NUM_DIGITS);

    conv_state_t             state_q, state_d;
    logic [BIN_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shreg_q, shreg_d;
    logic                    err_q, err_d;

    bcd_digit_t  digit;
    logic [3:0]  digit_bin;

    assign digit = shreg_q[4*NUM_DIGITS-1 -: 4];

    bcd_to_binary u_digit (
        .bcd (digit),
        .bin (digit_bin)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit_bin);
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef BCD_ERR_CHECK_EN
                err_d   = err_q | (digit > BCD_MAX);
`endif
                if (cnt_q == CNT_W'(NUM_DIGITS - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            err_q   <= err_d;
        end
    end

    // Handshake flags decode from state alone: no input-to-output combinational path.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONVERT);
    assign out_valid = (state_q == DONE);

`ifdef BCD_ERR_CHECK_EN
    assign out_err = err_q;
    assign out_bin = err_q ? '0 : acc_q;
`else
    assign out_err = 1'b0;
    assign out_bin = acc_q;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter (NUM_DIGITS=4, BIN_W=14).
module tb_bcd_seq_converter;

    localparam int ND = 4;
    localparam int BW = 14;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [4*ND-1:0] in_bcd;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_bin;
    logic          out_err;
    logic          busy;

    int total;
    int bad;

    bcd_seq_converter #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .busy      (busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request and check the busy window and the result; leaves DUT in DONE.
    task automatic convert(input string tag, input logic [4*ND-1:0] bcd,
                           input logic [31:0] exp_bin, input logic exp_err);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_bcd   = bcd;
        tick();
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        for (int i = 0; i < ND; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_early_valid"}, out_valid, 0);
            tick();
        end
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_bin"}, out_bin, exp_bin);
        chk({tag, "_out_err"}, out_err, exp_err);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, in_ready, 1);
        chk({tag, "_valid_low"}, out_valid, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;

        // 1. reset with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_bcd    = 16'($urandom_range(0, 65535));
            tick();
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_bin", out_bin, 0);
            chk("rst_out_err", out_err, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = '0;
        reset_n   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_valid", out_valid, 0);
            chk("post_rst_idle", in_ready, 1);
        end

        // 2. basic conversions
        convert("c1234", 16'h1234, 1234, 1'b0);
        drain("c1234");
        convert("c0000", 16'h0000, 0, 1'b0);
        drain("c0000");
        convert("c9999", 16'h9999, 9999, 1'b0);
        drain("c9999");

        // 3. backpressure; a request made while DONE is ignored
        convert("bp", 16'h0815, 815, 1'b0);
        in_valid = 1'b1;
        in_bcd   = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_bin", out_bin, 815);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        drain("bp");
        tick();
        chk("bp_5555_ignored", busy, 0);
        convert("bp_next", 16'h0321, 321, 1'b0);
        drain("bp_next");

        // 4. back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h0042;
        tick();
        in_bcd = 16'h0100;
        for (int i = 0; i < ND - 1; i++) tick();
        chk("b2b_still_busy", busy, 1);
        tick();
        chk("b2b_42_valid", out_valid, 1);
        chk("b2b_42_bin", out_bin, 42);
        tick();
        chk("b2b_idle", in_ready, 1);
        chk("b2b_not_busy", busy, 0);
        // second accept edge: ND CONVERT cycles + one DONE + one IDLE after the first
        tick();
        chk("b2b_second_accept", busy, 1);
        for (int i = 0; i < ND; i++) tick();
        chk("b2b_100_valid", out_valid, 1);
        chk("b2b_100_bin", out_bin, 100);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("b2b_back_idle", in_ready, 1);

        // 5. invalid digit nibble
`ifdef BCD_ERR_CHECK_EN
        convert("bad_digit", 16'h12A4, 0, 1'b1);
`else
        convert("bad_digit", 16'h12A4, 1304, 1'b0);
`endif
        drain("bad_digit");
        convert("after_bad", 16'h0056, 56, 1'b0);
        drain("after_bad");

        // 6. reset in the middle of CONVERT
        in_valid = 1'b1;
        in_bcd   = 16'h9876;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_bin", out_bin, 0);
        chk("mid_rst_err", out_err, 0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < ND + 1; i++) begin
            tick();
            chk("mid_rst_no_valid", out_valid, 0);
        end
        convert("c0007", 16'h0007, 7, 1'b0);
        drain("c0007");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
